load_buffer: RTL and testbench

//  In-order load queue sitting directly upstream of the load unit in the Tomasulo core.

---
 rtl/load_buffer_pkg.sv | 22 ++
 rtl/load_buffer_entry.sv | 78 +++++++
 rtl/load_buffer.sv | 133 +++++++++++++
 tb/tb_load_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_buffer_pkg.sv
// Shared definitions for the in-order load buffer: load type codes, ROB tag width
// and the dispatch FSM encoding.
package load_buffer_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } lb_state_e;

endpackage

// File: rtl/load_buffer_entry.sv
// One load-buffer slot: holds an issued load and snoops the CDB until its
// base operand arrives.
module load_buffer_entry #(
  parameter int ROB_W  = load_buffer_pkg::ROB_W,
  parameter int DATA_W = load_buffer_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic              clr_en_i,
  input  logic [2:0]        wr_type_i,
  input  logic              wr_base_rdy_i,
  input  logic [DATA_W-1:0] wr_base_val_i,
  input  logic [ROB_W-1:0]  wr_base_tag_i,
  input  logic [DATA_W-1:0] wr_offset_i,
  input  logic [ROB_W-1:0]  wr_rob_i,
  input  logic              cdb_enable_i,
  input  logic [ROB_W-1:0]  cdb_rob_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              valid_o,
  output logic [2:0]        type_o,
  output logic              base_rdy_o,
  output logic [DATA_W-1:0] base_val_o,
  output logic [DATA_W-1:0] offset_o,
  output logic [ROB_W-1:0]  rob_o
);

  logic              valid_q;
  logic [2:0]        type_q;
  logic              base_rdy_q;
  logic [DATA_W-1:0] base_val_q;
  logic [ROB_W-1:0]  base_tag_q;
  logic [DATA_W-1:0] offset_q;
  logic [ROB_W-1:0]  rob_q;

  logic snoop_hit;
  logic wr_hit;

  assign snoop_hit = valid_q && !base_rdy_q && cdb_enable_i && (cdb_rob_i == base_tag_q);
  // A load whose producer broadcasts in the issue cycle is captured as already ready.
  assign wr_hit    = !wr_base_rdy_i && cdb_enable_i && (cdb_rob_i == wr_base_tag_i);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
    end else if (clr_en_i) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: payload fields are deliberately not reset; valid_q alone qualifies them.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      type_q     <= wr_type_i;
      base_rdy_q <= wr_base_rdy_i || wr_hit;
      base_val_q <= wr_hit ? cdb_data_i : wr_base_val_i;
      base_tag_q <= wr_base_tag_i;
      offset_q   <= wr_offset_i;
      rob_q      <= wr_rob_i;
    end else if (snoop_hit) begin
      base_rdy_q <= 1'b1;
      base_val_q <= cdb_data_i;
    end
  end

  assign valid_o    = valid_q;
  assign type_o     = type_q;
  assign base_rdy_o = base_rdy_q;
  assign base_val_o = base_val_q;
  assign offset_o   = offset_q;
  assign rob_o      = rob_q;

endmodule

// File: rtl/load_buffer.sv
// In-order load queue ahead of the load unit: tracks pending bases via CDB snoop and
// dispatches the head load as a single-cycle loadEnable pulse followed by a gap.
module load_buffer #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = load_buffer_pkg::ROB_W,
  parameter int DATA_W = load_buffer_pkg::DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [2:0]               issue_type,
  input  logic                     issue_base_rdy,
  input  logic [DATA_W-1:0]        issue_base_val,
  input  logic [ROB_W-1:0]         issue_base_tag,
  input  logic [DATA_W-1:0]        issue_offset,
  input  logic [ROB_W-1:0]         issue_rob,
  input  logic                     cdb_enable,
  input  logic [ROB_W-1:0]         cdb_rob,
  input  logic [DATA_W-1:0]        cdb_data,
  input  logic                     flush,
  input  logic                     lu_busy,
  output logic                     lu_load_enable,
  output logic [2:0]               lu_load_type,
  output logic [DATA_W-1:0]        lu_addr,
  output logic [ROB_W-1:0]         lu_rob_num,
  output logic [$clog2(DEPTH):0]   count
);

  import load_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  lb_state_e         state_q;
  logic              lu_en_q;
  logic [2:0]        lu_type_q;
  logic [DATA_W-1:0] lu_addr_q;
  logic [ROB_W-1:0]  lu_rob_q;

  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_base_rdy;
  logic [2:0]        e_type     [DEPTH];
  logic [DATA_W-1:0] e_base_val [DEPTH];
  logic [DATA_W-1:0] e_offset   [DEPTH];
  logic [ROB_W-1:0]  e_rob      [DEPTH];

  logic enq;
  logic deq;

  // A slot freed by this cycle's dispatch is not offered to issue until next cycle.
  assign issue_ready = (count_q < CNT_W'(DEPTH));
  assign enq         = issue_valid && issue_ready;
  assign deq         = (state_q == ST_FIRE);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    load_buffer_entry #(
      .ROB_W (ROB_W),
      .DATA_W(DATA_W)
    ) u_entry (
      .clock        (clock),
      .reset        (reset),
      .flush_i      (flush),
      .wr_en_i      (enq && (tail_q == PTR_W'(i))),
      .clr_en_i     (deq && (head_q == PTR_W'(i))),
      .wr_type_i    (issue_type),
      .wr_base_rdy_i(issue_base_rdy),
      .wr_base_val_i(issue_base_val),
      .wr_base_tag_i(issue_base_tag),
      .wr_offset_i  (issue_offset),
      .wr_rob_i     (issue_rob),
      .cdb_enable_i (cdb_enable),
      .cdb_rob_i    (cdb_rob),
      .cdb_data_i   (cdb_data),
      .valid_o      (e_valid[i]),
      .type_o       (e_type[i]),
      .base_rdy_o   (e_base_rdy[i]),
      .base_val_o   (e_base_val[i]),
      .offset_o     (e_offset[i]),
      .rob_o        (e_rob[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      lu_en_q   <= 1'b0;
      lu_type_q <= '0;
      lu_addr_q <= '0;
      lu_rob_q  <= '0;
    end else if (flush) begin
      // A pulse already on the wire this cycle stays; everything queued is dropped.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
      lu_en_q <= 1'b0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (deq) head_q <= head_q + PTR_W'(1);
      if (enq && !deq)      count_q <= count_q + CNT_W'(1);
      else if (!enq && deq) count_q <= count_q - CNT_W'(1);

      lu_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (e_valid[head_q] && e_base_rdy[head_q] && !lu_busy) begin
            state_q   <= ST_FIRE;
            lu_en_q   <= 1'b1;
            lu_type_q <= e_type[head_q];
            lu_addr_q <= e_base_val[head_q] + e_offset[head_q];
            lu_rob_q  <= e_rob[head_q];
          end
        end
        ST_FIRE: state_q <= ST_GAP;
        ST_GAP:  if (!lu_busy) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lu_load_enable = lu_en_q;
  assign lu_load_type   = lu_type_q;
  assign lu_addr        = lu_addr_q;
  assign lu_rob_num     = lu_rob_q;
  assign count          = count_q;

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: expected dispatches are queued at issue time and
// matched against every loadEnable pulse seen on the load-unit side.
module tb_load_buffer;

  import load_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_type;
  logic        issue_base_rdy;
  logic [31:0] issue_base_val;
  logic [5:0]  issue_base_tag;
  logic [31:0] issue_offset;
  logic [5:0]  issue_rob;
  logic        cdb_enable;
  logic [5:0]  cdb_rob;
  logic [31:0] cdb_data;
  logic        flush;
  logic        lu_busy;
  logic        lu_load_enable;
  logic [2:0]  lu_load_type;
  logic [31:0] lu_addr;
  logic [5:0]  lu_rob_num;
  logic [2:0]  count;

  typedef struct {
    logic [5:0]  rob;
    logic [31:0] addr;
    logic [2:0]  typ;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;
  logic prev_en   = 1'b0;

  load_buffer #(.DEPTH(DEPTH), .ROB_W(6), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_type    (issue_type),
    .issue_base_rdy(issue_base_rdy),
    .issue_base_val(issue_base_val),
    .issue_base_tag(issue_base_tag),
    .issue_offset  (issue_offset),
    .issue_rob     (issue_rob),
    .cdb_enable    (cdb_enable),
    .cdb_rob       (cdb_rob),
    .cdb_data      (cdb_data),
    .flush         (flush),
    .lu_busy       (lu_busy),
    .lu_load_enable(lu_load_enable),
    .lu_load_type  (lu_load_type),
    .lu_addr       (lu_addr),
    .lu_rob_num    (lu_rob_num),
    .count         (count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load-unit side: every pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && lu_load_enable === 1'b1) begin
      pulse_cnt++;
      check("pulse_width", 64'(prev_en), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse_rob", 64'(lu_rob_num), 64'h3f_dead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dispatch_rob", 64'(lu_rob_num), 64'(e.rob));
        check("dispatch_addr", 64'(lu_addr), 64'(e.addr));
        check("dispatch_type", 64'(lu_load_type), 64'(e.typ));
      end
    end
    prev_en = lu_load_enable;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] typ, input logic rdy, input logic [31:0] base,
                       input logic [5:0] tag, input logic [31:0] off, input logic [5:0] rob);
    issue_valid    = 1'b1;
    issue_type     = typ;
    issue_base_rdy = rdy;
    issue_base_val = base;
    issue_base_tag = tag;
    issue_offset   = off;
    issue_rob      = rob;
    tick();
    issue_valid    = 1'b0;
  endtask

  task automatic push(input logic [5:0] rob, input logic [31:0] addr, input logic [2:0] typ);
    exp_t e;
    e.rob  = rob;
    e.addr = addr;
    e.typ  = typ;
    sb.push_back(e);
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_enable = 1'b1;
    cdb_rob    = tag;
    cdb_data   = data;
    tick();
    cdb_enable = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int k = 0;
    while (pulse_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(pulse_cnt), 64'(target));
  endtask

  initial begin
    int pc;
    reset = 1'b1; issue_valid = 1'b0; issue_type = '0; issue_base_rdy = 1'b0;
    issue_base_val = '0; issue_base_tag = '0; issue_offset = '0; issue_rob = '0;
    cdb_enable = 1'b0; cdb_rob = '0; cdb_data = '0; flush = 1'b0; lu_busy = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(issue_ready), 64'd1);
    check("rst_enable", 64'(lu_load_enable), 64'd0);
    check("rst_addr", 64'(lu_addr), 64'd0);
    check("rst_rob", 64'(lu_rob_num), 64'd0);
    check("rst_type", 64'(lu_load_type), 64'd0);

    // Ready base: enqueue, fire one cycle later, single-cycle pulse.
    push(6'd5, 32'h108, LD_LW);
    issue(LD_LW, 1'b1, 32'h100, 6'd0, 32'h8, 6'd5);
    check("t2_no_fire_yet", 64'(lu_load_enable), 64'd0);
    tick();
    check("t2_fire", 64'(lu_load_enable), 64'd1);
    check("t2_addr", 64'(lu_addr), 64'h108);
    tick();
    check("t2_pulse_end", 64'(lu_load_enable), 64'd0);
    check("t2_count", 64'(count), 64'd0);
    check("t2_addr_hold", 64'(lu_addr), 64'h108);
    tick(); tick();

    // Pending base resolved over the CDB; a non-matching tag leaves it waiting.
    pc = pulse_cnt;
    push(6'd7, 32'h1FFC, LD_LH);
    issue(LD_LH, 1'b0, 32'h0, 6'd3, 32'hFFFF_FFFC, 6'd7);
    tick();
    cdb(6'd4, 32'h9999);
    tick(); tick();
    check("t3_pending_no_pulse", 64'(pulse_cnt), 64'(pc));
    check("t3_pending_count", 64'(count), 64'd1);
    cdb(6'd3, 32'h2000);
    wait_pulses("t3_dispatch", pc + 1, 10);
    tick(); tick(); tick();

    // Full queue with pending head: no bypass, no extra enqueue, in-order drain.
    pc = pulse_cnt;
    push(6'd10, 32'h1040, LD_LB);
    push(6'd11, 32'h10, LD_LBU);
    push(6'd12, 32'h24, LD_LHU);
    push(6'd13, 32'h3C, LD_LW);
    issue(LD_LB,  1'b0, 32'h0,  6'd20, 32'h40, 6'd10);
    issue(LD_LBU, 1'b1, 32'h10, 6'd0,  32'h0,  6'd11);
    issue(LD_LHU, 1'b1, 32'h20, 6'd0,  32'h4,  6'd12);
    issue(LD_LW,  1'b1, 32'h30, 6'd0,  32'hC,  6'd13);
    check("t4_full_count", 64'(count), 64'd4);
    check("t4_not_ready", 64'(issue_ready), 64'd0);
    issue(LD_LW, 1'b1, 32'h500, 6'd0, 32'h0, 6'd14);
    tick(); tick();
    check("t4_extra_dropped", 64'(count), 64'd4);
    check("t4_no_bypass", 64'(pulse_cnt), 64'(pc));
    cdb(6'd20, 32'h1000);
    wait_pulses("t4_drain", pc + 4, 40);
    tick(); tick(); tick();
    check("t4_empty", 64'(count), 64'd0);

    // Busy load unit holds the FSM in GAP.
    pc = pulse_cnt;
    push(6'd21, 32'h200, LD_LW);
    push(6'd22, 32'h310, LD_LH);
    issue(LD_LW, 1'b1, 32'h200, 6'd0, 32'h0,  6'd21);
    issue(LD_LH, 1'b1, 32'h300, 6'd0, 32'h10, 6'd22);
    lu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_busy_no_pulse", 64'(lu_load_enable), 64'd0);
    end
    check("t5_one_fired", 64'(pulse_cnt), 64'(pc + 1));
    check("t5_count", 64'(count), 64'd1);
    lu_busy = 1'b0;
    wait_pulses("t5_after_busy", pc + 2, 10);
    tick(); tick(); tick();

    // Address wrap, then flush with two queued and an enqueue in the flush cycle.
    pc = pulse_cnt;
    push(6'd30, 32'h4, LD_LW);
    issue(LD_LW, 1'b1, 32'hFFFF_FFFC, 6'd0, 32'h8, 6'd30);
    wait_pulses("t6_wrap", pc + 1, 10);
    tick(); tick(); tick();
    pc = pulse_cnt;
    lu_busy = 1'b1;
    issue(LD_LW, 1'b1, 32'h600, 6'd0, 32'h0, 6'd31);
    issue(LD_LW, 1'b1, 32'h700, 6'd0, 32'h0, 6'd32);
    check("t6_queued", 64'(count), 64'd2);
    flush = 1'b1;
    issue(LD_LW, 1'b1, 32'h800, 6'd0, 32'h0, 6'd33);
    flush = 1'b0;
    check("t6_flush_count", 64'(count), 64'd0);
    check("t6_flush_ready", 64'(issue_ready), 64'd1);
    lu_busy = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t6_no_pulse", 64'(pulse_cnt), 64'(pc));

    // Reset while in GAP with three entries queued.
    pc = pulse_cnt;
    push(6'd40, 32'h900, LD_LBU);
    issue(LD_LBU, 1'b1, 32'h900, 6'd0, 32'h0, 6'd40);
    tick();
    lu_busy = 1'b1;
    issue(LD_LW, 1'b1, 32'hA00, 6'd0, 32'h0, 6'd41);
    issue(LD_LW, 1'b1, 32'hB00, 6'd0, 32'h0, 6'd42);
    issue(LD_LW, 1'b1, 32'hC00, 6'd0, 32'h0, 6'd43);
    check("t1_three_queued", 64'(count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t1_count", 64'(count), 64'd0);
    check("t1_ready", 64'(issue_ready), 64'd1);
    check("t1_enable", 64'(lu_load_enable), 64'd0);
    check("t1_addr", 64'(lu_addr), 64'd0);
    lu_busy = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t1_only_first", 64'(pulse_cnt), 64'(pc + 1));
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
